// File: rtl/aesa_radar_hps_fpga_event_register_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aesa_radar_hps_fpga_event_register_if : Avalon-MM slave bus plus IRQ line
// Rev 1.0
// ---------------------------------------------------------------------------
interface aesa_radar_hps_fpga_event_register_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/aesa_radar_hps_fpga_event_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aesa_radar_hps_fpga_event_register : synchronised edge capture, IRQ mask
// and saturating event counter behind a 4-word Avalon-MM register map.
// Rev 1.0
// ---------------------------------------------------------------------------
module aesa_radar_hps_fpga_event_register #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in_port,
  aesa_radar_hps_fpga_event_register_if.slave bus
);

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_MASK  = 2'd1;
  localparam logic [1:0] ADDR_EDGE  = 2'd2;
  localparam logic [1:0] ADDR_COUNT = 2'd3;
  localparam logic [2:0] ARM_DONE   = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_chain_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       arm_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;
  logic [WIDTH-1:0] raw_edge;
  logic [WIDTH-1:0] edge_det;
  logic             armed;
  logic             event_hit;
  logic             wr_en;
  logic             unused_wdata;

  assign sync_q       = sync_chain_q[SYNC_STAGES-1];
  assign armed        = (arm_q == ARM_DONE);
  assign wr_en        = bus.chipselect & ~bus.write_n;
  assign unused_wdata = ^bus.writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign raw_edge = sync_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign raw_edge = ~sync_q & prev_q;
    end else begin : g_any
      assign raw_edge = sync_q ^ prev_q;
    end
  endgenerate

  // The chain and prev_q come out of reset at zero, so hold off edge
  // reporting until the first real input value has propagated through.
  assign edge_det  = armed ? raw_edge : '0;
  assign event_hit = |edge_det;

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    cnt_d  = cnt_q;
    rd_d   = '0;

    if (wr_en && bus.address == ADDR_MASK) begin
      mask_d = bus.writedata[WIDTH-1:0];
    end

    // Clear first, then OR in new edges so a coincident edge survives.
    if (wr_en && bus.address == ADDR_EDGE) begin
      cap_d = cap_q & ~bus.writedata[WIDTH-1:0];
    end
    cap_d = cap_d | edge_det;

    if (wr_en && bus.address == ADDR_COUNT) begin
      cnt_d = event_hit ? 16'd1 : 16'd0;
    end else if (event_hit && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (bus.address)
      ADDR_DATA:  rd_d[WIDTH-1:0] = sync_q;
      ADDR_MASK:  rd_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE:  rd_d[WIDTH-1:0] = cap_q;
      ADDR_COUNT: rd_d[15:0]      = cnt_q;
      default:    rd_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain_q[i] <= '0;
      end
      prev_q <= '0;
      arm_q  <= '0;
      mask_q <= '0;
      cap_q  <= '0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      sync_chain_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain_q[i] <= sync_chain_q[i-1];
      end
      prev_q <= sync_q;
      if (!armed) begin
        arm_q <= arm_q + 3'd1;
      end
      mask_q <= mask_d;
      cap_q  <= cap_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  assign bus.readdata = rd_q;
  assign bus.irq      = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_aesa_radar_hps_fpga_event_register.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_aesa_radar_hps_fpga_event_register : directed stimulus with a queued
// scoreboard; a separate monitor pops and compares readdata/irq.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_aesa_radar_hps_fpga_event_register;

  logic       clk;
  logic       reset_n;
  logic [7:0] in_port;
  logic       rd_req;
  logic       pend_q;
  logic       async_req;
  int         pass_cnt;
  int         total_cnt;

  logic [32:0] exp_q [$];
  string       name_q [$];

  aesa_radar_hps_fpga_event_register_if bus ();

  aesa_radar_hps_fpga_event_register #(
    .WIDTH      (8),
    .EDGE_TYPE  (0),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .in_port(in_port),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) pend_q <= rd_req;

  // Monitor: one queued expectation per requested sample.
  task automatic do_check();
    logic [32:0] e;
    logic [31:0] act;
    string       n;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL scoreboard: sample with empty queue, got 0x%08h required an entry", bus.readdata);
    end else begin
      e   = exp_q.pop_front();
      n   = name_q.pop_front();
      act = e[32] ? {31'b0, bus.irq} : bus.readdata;
      if (act === e[31:0]) pass_cnt++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", n, act, e[31:0]);
    end
  endtask

  always begin
    @(negedge clk or posedge async_req);
    if (async_req || pend_q) do_check();
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = cs;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  // Result is compared after the next rising edge.
  task automatic exp_rd(input logic [1:0] a, input logic [31:0] e, input string n);
    bus.address = a;
    exp_q.push_back({1'b0, e});
    name_q.push_back(n);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic exp_irq(input logic e, input string n);
    exp_q.push_back({1'b1, 31'b0, e});
    name_q.push_back(n);
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  // Compared immediately, without a clock edge.
  task automatic async_chk(input logic is_irq, input logic [31:0] e, input string n);
    exp_q.push_back({is_irq, e});
    name_q.push_back(n);
    async_req = 1'b1;
    #1;
    async_req = 1'b0;
    #1;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rd_req         = 1'b0;
    async_req      = 1'b0;
    reset_n        = 1'b1;
    in_port        = 8'hA5;
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    #1 reset_n = 1'b0;
    #1;
    async_chk(1'b0, 32'h0, "reset_readdata");
    async_chk(1'b1, 32'h0, "reset_irq");

    // Start-up: A5 held through release, no spurious capture.
    tick(2);
    reset_n = 1'b1;
    tick(2);
    exp_rd(2'd0, 32'h0000_00A5, "startup_data");
    exp_rd(2'd2, 32'h0, "startup_edge_capture");
    exp_rd(2'd3, 32'h0, "startup_event_count");
    exp_irq(1'b0, "startup_irq");

    // Masked bit0 rise: irq exactly two edges after sampling, then W1C.
    wr(2'd1, 32'h01, 1'b1);
    in_port = 8'hA4;
    tick(4);
    exp_rd(2'd2, 32'h0, "falling_ignored");
    in_port = 8'hA5;
    exp_irq(1'b0, "irq_latency_edge_n");
    exp_irq(1'b0, "irq_latency_edge_n1");
    exp_irq(1'b1, "irq_set");
    exp_rd(2'd2, 32'h01, "edge_capture_bit0");
    wr(2'd2, 32'h01, 1'b1);
    exp_irq(1'b0, "irq_cleared");

    // Set wins over a coincident clear.
    in_port = 8'hA4;
    tick(4);
    in_port = 8'hA5;
    tick(2);
    wr(2'd2, 32'h01, 1'b1);
    exp_rd(2'd2, 32'h01, "set_wins_capture");
    exp_irq(1'b1, "set_wins_irq");
    exp_rd(2'd3, 32'h2, "event_count_two");
    wr(2'd2, 32'hFF, 1'b1);
    exp_rd(2'd2, 32'h0, "capture_cleared_all");

    // Bits 0 and 7 rise together: one count.
    in_port = 8'h24;
    tick(4);
    exp_rd(2'd3, 32'h2, "count_after_fall");
    wr(2'd3, 32'h0, 1'b1);
    in_port = 8'hA5;
    tick(4);
    exp_rd(2'd2, 32'h81, "dual_rise_capture");
    exp_rd(2'd3, 32'h1, "dual_rise_count");
    in_port = 8'h24;
    tick(4);
    exp_rd(2'd2, 32'h81, "dual_fall_capture");
    exp_rd(2'd3, 32'h1, "dual_fall_count");

    // Ignored writes: chipselect low, and address 0.
    wr(2'd3, 32'h0, 1'b0);
    exp_rd(2'd3, 32'h1, "nocs_write_ignored");
    wr(2'd0, 32'hFF, 1'b1);
    exp_rd(2'd1, 32'h01, "addr0_write_ignored");
    wr(2'd1, 32'h00, 1'b1);
    exp_irq(1'b0, "mask_off_irq");
    wr(2'd1, 32'h81, 1'b1);
    exp_irq(1'b1, "mask_on_irq");
    exp_rd(2'd1, 32'h81, "mask_readback");

    // Count clear coincident with an edge leaves 1.
    in_port = 8'hA5;
    tick(2);
    wr(2'd3, 32'h0, 1'b1);
    exp_rd(2'd3, 32'h1, "clear_with_event");

    // Saturation: alternating patterns give an edge every cycle.
    for (int i = 0; i < 65600; i++) begin
      in_port = i[0] ? 8'hAA : 8'h55;
      @(negedge clk);
    end
    in_port = 8'h00;
    tick(4);
    exp_rd(2'd3, 32'h0000_FFFF, "count_saturated");
    exp_rd(2'd2, 32'hFF, "capture_all_bits");
    wr(2'd3, 32'h0, 1'b1);
    exp_rd(2'd3, 32'h0, "count_cleared");

    // Five bit3 pulses, then asynchronous reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      in_port = 8'h08;
      tick(2);
      in_port = 8'h00;
      tick(2);
    end
    tick(3);
    exp_rd(2'd3, 32'h5, "count_five");
    exp_irq(1'b1, "irq_before_reset");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    async_chk(1'b0, 32'h0, "midreset_readdata");
    async_chk(1'b1, 32'h0, "midreset_irq");
    @(negedge clk);
    reset_n = 1'b1;
    tick(4);
    exp_rd(2'd1, 32'h0, "post_reset_mask");
    exp_rd(2'd2, 32'h0, "post_reset_capture");
    exp_rd(2'd3, 32'h0, "post_reset_count");
    exp_irq(1'b0, "post_reset_irq");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aesa_radar_hps_fpga_event_register.md
AESA_RADAR_HPS_FPGA_EVENT_REGISTER -- requirements
Module: aesa_radar_hps_fpga_event_register

Interface
REQ-001 Parameter WIDTH, default 8: number of input bits, legal range 1..32.
REQ-002 Parameter EDGE_TYPE, default 0: 0 = rising, 1 = falling, 2 = any edge.
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth, legal range 2..3.
REQ-004 clk  input  1  single clock for all logic.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 address  input  2  Avalon-MM slave word address.
REQ-007 chipselect  input  1  slave select; a write is only accepted with chipselect=1.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external status inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt request, active high.

Function
REQ-013 Register map: 0 = DATA (RO), 1 = IRQ_MASK (RW), 2 = EDGE_CAPTURE (W1C), 3 = EVENT_COUNT (RO, clear-on-write).
REQ-014 in_port SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is sync_q.
REQ-015 prev_q SHALL register sync_q every clock.
REQ-016 Per-bit edge: rising = sync_q & ~prev_q; falling = ~sync_q & prev_q; any = sync_q ^ prev_q, selected by EDGE_TYPE.
REQ-017 Edge detection SHALL be masked until an arm counter reaches SYNC_STAGES+1 clocks after reset deassertion, so that no spurious edge is reported at start-up.
REQ-018 A detected edge on bit i SHALL set EDGE_CAPTURE[i] on the next clock edge; the bit stays set until cleared.
REQ-019 A write to address 2 with writedata[i]=1 SHALL clear EDGE_CAPTURE[i]; writedata[i]=0 leaves the bit unchanged.
REQ-020 If a clear and a new edge hit the same bit in the same cycle, set SHALL win.
REQ-021 A write to address 1 SHALL load IRQ_MASK with writedata[WIDTH-1:0].
REQ-022 irq SHALL equal the OR over all bits of (EDGE_CAPTURE & IRQ_MASK), combinational from those registers.
REQ-023 EVENT_COUNT is 16 bits.
  - Increments by 1 in any cycle where at least one unmasked-by-arm edge is detected, regardless of how many bits fire.
  - Saturates at 0xFFFF.
REQ-024 Any write to address 3 SHALL clear EVENT_COUNT; if an event occurs in the same cycle, the result SHALL be 1.
REQ-025 Writes to address 0, and writes with chipselect=0, SHALL have no effect.
REQ-026 readdata SHALL be updated every clock with mux(address), independent of any read strobe (read latency 1 cycle).
  - Address 0: sync_q.
  - Address 1: IRQ_MASK.
  - Address 2: EDGE_CAPTURE.
  - Address 3: EVENT_COUNT.
  - Unused upper bits are zero.
REQ-027 Latency: an in_port change sampled at clock edge n SHALL appear in sync_q after edge n+SYNC_STAGES-1.
  - EDGE_CAPTURE, irq and EVENT_COUNT update at edge n+SYNC_STAGES.
  - DATA readdata also updates at edge n+SYNC_STAGES.

Reset
REQ-028 On reset_n=0, all of the following SHALL be 0 immediately (asynchronous): sync chain, prev_q, arm counter, IRQ_MASK, EDGE_CAPTURE, EVENT_COUNT and readdata. irq SHALL therefore be 0.
REQ-029 Reset asserted mid-operation SHALL discard pending edges and counts; there is no partial state after release.

Verification (WIDTH=8, EDGE_TYPE=0, SYNC_STAGES=2)
REQ-030 Hold in_port=0xA5 through reset release, address=0 -> readdata=0x000000A5 by the 3rd clock; EDGE_CAPTURE=0; EVENT_COUNT=0; irq=0.
REQ-031 IRQ_MASK=0x01, then in_port bit0 0->1 -> EDGE_CAPTURE=0x01 and irq=1 two edges after sampling; write 0x01 to address 2 -> irq=0 the next cycle.
REQ-032 Bit0 rising edge detected in the same cycle as a write of 0x01 to address 2 -> EDGE_CAPTURE[0]=1 and irq remains 1.
REQ-033 Toggle bit3 0->1->0 70000 times -> EVENT_COUNT saturates at 0xFFFF; a write to address 3 -> 0x0000; a write coinciding with an edge -> 0x0001.
REQ-034 Bits 0 and 7 rise in the same cycle -> EDGE_CAPTURE=0x81 and EVENT_COUNT incremented by exactly 1; a falling edge on either bit -> no change.
REQ-035 Assert reset_n=0 while irq=1 and EVENT_COUNT=5 -> irq, readdata and all registers are 0 without waiting for a clock edge.
